// File: rtl/pattern_match_sched.sv
// Round-robin scheduler that time-shares one registered pattern matcher among
// NCH serial bit streams, keeping a private bit history for each stream.
module pattern_match_sched #(
  parameter int NCH  = 4,
  parameter int PLEN = 4,
  parameter int CNTW = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          req,
  input  logic [NCH-1:0]          bit_in,
  output logic [NCH-1:0]          gnt,
  input  logic                    cfg_load,
  input  logic [PLEN-1:0]         cfg_pattern,
  output logic                    y_valid,
  output logic                    y,
  output logic [$clog2(NCH)-1:0]  y_ch,
  output logic [CNTW-1:0]         match_cnt
);

  localparam int IDXW  = $clog2(NCH);
  localparam int FILLW = $clog2(PLEN + 1);
  localparam logic [FILLW-1:0] FILL_MAX = FILLW'(PLEN);
  localparam logic [FILLW-1:0] FILL_ARM = FILLW'(PLEN - 1);
  localparam logic [CNTW-1:0]  CNT_MAX  = '1;
  localparam logic [IDXW:0]    NCH_W    = (IDXW + 1)'(NCH);

  logic [IDXW-1:0] ptr_reg;
  logic [IDXW-1:0] ptr_next;
  logic [PLEN-1:0] pat_reg;
  logic [IDXW-1:0] gnt_idx;
  logic            gnt_found;
  logic            gnt_any;
  logic [IDXW:0]   scan_sum;
  logic [NCH-1:0]  hit_vec;
  logic            svc_hit;

  // Scan from ptr upward with wrap; first requester wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    scan_sum  = '0;
    for (int k = 0; k < NCH; k++) begin
      scan_sum = {1'b0, ptr_reg} + (IDXW + 1)'(k);
      if (scan_sum >= NCH_W) begin
        scan_sum = scan_sum - NCH_W;
      end
      if (!gnt_found && req[scan_sum[IDXW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (gnt_found && !reset && !cfg_load) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign gnt_any  = |gnt;
  assign ptr_next = (gnt_idx == IDXW'(NCH - 1)) ? '0 : gnt_idx + IDXW'(1);
  assign svc_hit  = |(hit_vec & gnt);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [PLEN-1:0]  hist_reg;
    logic [PLEN-1:0]  hist_next;
    logic [FILLW-1:0] fill_reg;

    assign hist_next   = {hist_reg[PLEN-2:0], bit_in[gi]};
    // A match needs PLEN fresh bits, counting the one arriving now.
    assign hit_vec[gi] = (hist_next == pat_reg) && (fill_reg >= FILL_ARM);

    always_ff @(posedge clk) begin
      if (reset || cfg_load) begin
        hist_reg <= '0;
        fill_reg <= '0;
      end else if (gnt[gi]) begin
        hist_reg <= hist_next;
        if (fill_reg != FILL_MAX) begin
          fill_reg <= fill_reg + FILLW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg   <= '0;
      pat_reg   <= '0;
      y_valid   <= 1'b0;
      y         <= 1'b0;
      y_ch      <= '0;
      match_cnt <= '0;
    end else if (cfg_load) begin
      pat_reg   <= cfg_pattern;
      match_cnt <= '0;
      y_valid   <= 1'b0;
      y         <= 1'b0;
    end else if (gnt_any) begin
      ptr_reg <= ptr_next;
      y_valid <= 1'b1;
      y       <= svc_hit;
      y_ch    <= gnt_idx;
      if (svc_hit && match_cnt != CNT_MAX) begin
        match_cnt <= match_cnt + CNTW'(1);
      end
    end else begin
      y_valid <= 1'b0;
      y       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_match_sched.sv
// Bench for pattern_match_sched: directed scenarios plus random traffic, all
// checked against an arithmetic per-channel history model.
module tb_pattern_match_sched;

  localparam int NCH  = 4;
  localparam int PLEN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [3:0] cfg_pattern;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] gnt, gnt2;
  logic       y_valid, y, y_valid2, y2;
  logic [1:0] y_ch, y_ch2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int         m_ptr, m_pat, m_cnt, m_cnt2;
  int         m_hist[NCH];
  int         m_fill[NCH];
  logic [3:0] exp_gnt;
  logic       exp_yv, exp_y;
  logic [1:0] exp_ych;

  pattern_match_sched #(.NCH(NCH), .PLEN(PLEN), .CNTW(8)) u_dut (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .gnt(gnt),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .y_valid(y_valid),
    .y(y), .y_ch(y_ch), .match_cnt(match_cnt)
  );

  pattern_match_sched #(.NCH(NCH), .PLEN(PLEN), .CNTW(2)) u_dut2 (
    .clk(clk), .reset(reset), .req(req), .bit_in(bit_in), .gnt(gnt2),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .y_valid(y_valid2),
    .y(y2), .y_ch(y_ch2), .match_cnt(match_cnt2)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and advance the model to its post-edge state.
  task automatic apply(input logic r, input logic cl, input logic [3:0] pat,
                       input logic [3:0] rq, input logic [3:0] bi);
    int g;
    int c;
    bit hit;
    reset = r; cfg_load = cl; cfg_pattern = pat; req = rq; bit_in = bi;
    g = -1;
    if (!r && !cl) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (g < 0 && rq[c]) g = c;
      end
    end
    exp_gnt = (g < 0) ? 4'b0000 : 4'(1 << g);
    if (r) begin
      m_ptr = 0; m_pat = 0; m_cnt = 0; m_cnt2 = 0;
      for (int k = 0; k < NCH; k++) begin m_hist[k] = 0; m_fill[k] = 0; end
      exp_yv = 0; exp_y = 0; exp_ych = 0;
    end else if (cl) begin
      m_pat = int'(pat); m_cnt = 0; m_cnt2 = 0;
      for (int k = 0; k < NCH; k++) begin m_hist[k] = 0; m_fill[k] = 0; end
      exp_yv = 0; exp_y = 0;
    end else if (g >= 0) begin
      m_hist[g] = ((m_hist[g] * 2) + int'(bi[g])) % (1 << PLEN);
      m_fill[g] = m_fill[g] + 1;
      hit = (m_fill[g] >= PLEN) && (m_hist[g] == m_pat);
      exp_yv = 1; exp_y = hit; exp_ych = 2'(g);
      if (hit && m_cnt < 255) m_cnt = m_cnt + 1;
      if (hit && m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
      m_ptr = (g + 1) % NCH;
    end else begin
      exp_yv = 0; exp_y = 0;
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1, 0, 4'($urandom), 4'($urandom), 4'($urandom));
      vec_cnt++;
      if (gnt !== 4'b0000) begin err_cnt++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
      tick();
      vec_cnt++;
      if ({y_valid, y, y_ch, match_cnt, match_cnt2} !== 14'd0) begin
        err_cnt++;
        $display("FAIL reset_out: got yv=%b y=%b ych=%0d cnt=%0d cnt2=%0d want all 0",
                 y_valid, y, y_ch, match_cnt, match_cnt2);
      end
    end
  endtask

  task automatic test_single_match();
    logic [3:0] stream = 4'b1101;
    logic [3:0] exp_y_seq = 4'b0001;
    apply(0, 1, 4'b1101, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 4'b0000, 4'b0001, {3'b000, stream[3-i]});
      vec_cnt++;
      if (gnt !== 4'b0001) begin err_cnt++; $display("FAIL single_gnt %0d: got %b want 0001", i, gnt); end
      tick();
      vec_cnt++;
      if ({y_valid, y, y_ch} !== {1'b1, exp_y_seq[3-i], 2'd0} || y !== exp_y) begin
        err_cnt++;
        $display("FAIL single_out %0d: got yv=%b y=%b ych=%0d want yv=1 y=%b ych=0",
                 i, y_valid, y, y_ch, exp_y_seq[3-i]);
      end
    end
    vec_cnt++;
    if (match_cnt !== 8'd1) begin err_cnt++; $display("FAIL single_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_overlap();
    logic [6:0] stream = 7'b1101101;
    logic [6:0] exp_y_seq = 7'b0001001;
    apply(0, 1, 4'b1101, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 7; i++) begin
      apply(0, 0, 4'b0000, 4'b0010, {2'b00, stream[6-i], 1'b0});
      vec_cnt++;
      if (gnt !== 4'b0010) begin err_cnt++; $display("FAIL overlap_gnt %0d: got %b want 0010", i, gnt); end
      tick();
      vec_cnt++;
      if ({y_valid, y, y_ch} !== {1'b1, exp_y_seq[6-i], 2'd1}) begin
        err_cnt++;
        $display("FAIL overlap_out %0d: got yv=%b y=%b ych=%0d want yv=1 y=%b ych=1",
                 i, y_valid, y, y_ch, exp_y_seq[6-i]);
      end
    end
    vec_cnt++;
    if (match_cnt !== 8'd2) begin err_cnt++; $display("FAIL overlap_cnt: got %0d want 2", match_cnt); end
  endtask

  task automatic test_round_robin();
    logic [3:0] want_g;
    apply(1, 0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 4'b0000, (i < 6) ? 4'b0101 : 4'b1101, 4'($urandom));
      want_g = (i < 6) ? ((i % 2 == 0) ? 4'b0001 : 4'b0100) : exp_gnt;
      vec_cnt++;
      if (gnt !== want_g || gnt !== exp_gnt) begin
        err_cnt++; $display("FAIL rr_gnt %0d: got %b want %b", i, gnt, want_g);
      end
      tick();
      vec_cnt++;
      if ({y_valid, y_ch} !== {1'b1, exp_ych}) begin
        err_cnt++; $display("FAIL rr_ych %0d: got yv=%b ych=%0d want yv=1 ych=%0d", i, y_valid, y_ch, exp_ych);
      end
    end
  endtask

  task automatic test_fill_gating();
    logic want_y;
    apply(1, 0, 4'b0000, 4'b0000, 4'b0000);
    tick();
    for (int i = 0; i < 10; i++) begin
      apply(0, 0, 4'b0000, 4'b1001, 4'b0000);
      vec_cnt++;
      if (gnt !== ((i % 2 == 0) ? 4'b0001 : 4'b1000)) begin
        err_cnt++; $display("FAIL fill_gnt %0d: got %b want %b", i, gnt, (i % 2 == 0) ? 4'b0001 : 4'b1000);
      end
      tick();
      want_y = (i / 2) >= 3;
      vec_cnt++;
      if ({y_valid, y} !== {1'b1, want_y} || y !== exp_y) begin
        err_cnt++; $display("FAIL fill_y %0d: got yv=%b y=%b want yv=1 y=%b", i, y_valid, y, want_y);
      end
    end
  endtask

  task automatic test_midstream();
    logic [2:0] pre = 3'b110;
    for (int pass = 0; pass < 2; pass++) begin
      apply(0, 1, 4'b1101, 4'b0000, 4'b0000);
      tick();
      for (int i = 0; i < 3; i++) begin
        apply(0, 0, 4'b0000, 4'b0100, {1'b0, pre[2-i], 2'b00});
        tick();
      end
      if (pass == 0) apply(0, 1, 4'b1101, 4'b0100, 4'b0100);
      else           apply(1, 0, 4'b0000, 4'b0100, 4'b0100);
      vec_cnt++;
      if (gnt !== 4'b0000) begin err_cnt++; $display("FAIL mid_gnt pass %0d: got %b want 0000", pass, gnt); end
      tick();
      vec_cnt++;
      if ({y_valid, y, match_cnt} !== 10'd0 || (pass == 1 && y_ch !== 2'd0)) begin
        err_cnt++; $display("FAIL mid_clear pass %0d: got yv=%b y=%b ych=%0d cnt=%0d want 0",
                            pass, y_valid, y, y_ch, match_cnt);
      end
      apply(0, 0, 4'b0000, 4'b0100, 4'b0100);
      tick();
      vec_cnt++;
      if ({y_valid, y, y_ch, match_cnt} !== {1'b1, 1'b0, 2'd2, 8'd0}) begin
        err_cnt++; $display("FAIL mid_after pass %0d: got yv=%b y=%b ych=%0d cnt=%0d want yv=1 y=0 ych=2 cnt=0",
                            pass, y_valid, y, y_ch, match_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    int want_c;
    apply(0, 1, 4'b1111, 4'b0000, 4'b0000);
    tick();
    for (int k = 1; k <= 10; k++) begin
      apply(0, 0, 4'b0000, 4'b0001, 4'b0001);
      tick();
      want_c = (k < 4) ? 0 : k - 3;
      vec_cnt++;
      if (y !== (k >= 4) || match_cnt !== 8'(want_c) || match_cnt2 !== 2'((want_c > 3) ? 3 : want_c)) begin
        err_cnt++; $display("FAIL sat %0d: got y=%b cnt=%0d cnt2=%0d want y=%b cnt=%0d cnt2=%0d",
                            k, y, match_cnt, match_cnt2, k >= 4, want_c, (want_c > 3) ? 3 : want_c);
      end
    end
  endtask

  task automatic test_random();
    logic r, cl;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 59) == 0);
      cl = ($urandom_range(0, 24) == 0);
      // Narrow pattern choice so matches actually occur in random streams.
      apply(r, cl, ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom),
            4'($urandom), ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b1111);
      vec_cnt++;
      if (gnt !== exp_gnt || gnt2 !== exp_gnt) begin
        err_cnt++; $display("FAIL rand_gnt %0d: got %b/%b want %b", i, gnt, gnt2, exp_gnt);
      end
      tick();
      vec_cnt++;
      if ({y_valid, y, y_ch, match_cnt, match_cnt2} !== {exp_yv, exp_y, exp_ych, 8'(m_cnt), 2'(m_cnt2)}) begin
        err_cnt++; $display("FAIL rand_out %0d: got yv=%b y=%b ych=%0d cnt=%0d cnt2=%0d want yv=%b y=%b ych=%0d cnt=%0d cnt2=%0d",
                            i, y_valid, y, y_ch, match_cnt, match_cnt2, exp_yv, exp_y, exp_ych, m_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; req = '0; bit_in = '0;
    m_ptr = 0; m_pat = 0; m_cnt = 0; m_cnt2 = 0;
    for (int k = 0; k < NCH; k++) begin m_hist[k] = 0; m_fill[k] = 0; end
    exp_gnt = '0; exp_yv = 0; exp_y = 0; exp_ych = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_match();
    test_overlap();
    test_round_robin();
    test_fill_gating();
    test_midstream();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
